// File: rtl/nn_pkg.sv
// Shared numeric formats for the hidden-layer neuron datapath.
package nn_pkg;

    localparam int IN_W  = 12;
    localparam int ACC_W = 23;
    localparam logic [21:0] MAG_MAX = 22'h3FFFFF;

    // 12-bit sign-magnitude fraction: sign bit plus Q0.11 magnitude.
    typedef struct packed {
        logic        sign;
        logic [10:0] mag;
    } in_sm_t;

    // 23-bit sign-magnitude fraction: sign bit plus Q0.22 magnitude.
    typedef struct packed {
        logic        sign;
        logic [21:0] mag;
    } acc_sm_t;

    // ReLU on a sign-magnitude value: any negative value becomes +0.
    function automatic acc_sm_t relu(input acc_sm_t v);
        acc_sm_t r;
        if (v.sign) begin
            r = acc_sm_t'(23'h000000);
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/sm_add_sat.sv
// Saturating sign-magnitude adder for Q0.22 values; zero results are always +0.
module sm_add_sat
    import nn_pkg::*;
(
    input  acc_sm_t a,
    input  acc_sm_t b,
    output acc_sm_t sum
);

    logic [22:0] mag_sum_s;
    acc_sm_t     res_s;

    // Add or subtract magnitudes depending on sign agreement, clamp overflow.
    always_comb begin
        mag_sum_s = {1'b0, a.mag} + {1'b0, b.mag};
        res_s     = acc_sm_t'(23'h000000);
        if (a.sign == b.sign) begin
            res_s.sign = a.sign;
            if (mag_sum_s[22]) begin
                res_s.mag = MAG_MAX;
            end else begin
                res_s.mag = mag_sum_s[21:0];
            end
        end else if (a.mag > b.mag) begin
            res_s.sign = a.sign;
            res_s.mag  = a.mag - b.mag;
        end else if (b.mag > a.mag) begin
            res_s.sign = b.sign;
            res_s.mag  = b.mag - a.mag;
        end else begin
            res_s.sign = 1'b0;
            res_s.mag  = 22'h000000;
        end

        sum = res_s;
        if (res_s.mag == 22'h000000) begin
            sum.sign = 1'b0;
        end else begin
            sum.sign = res_s.sign;
        end
    end

endmodule

// File: rtl/sm_frac_mult.sv
// Sign-magnitude fractional multiplier: Q0.11 x Q0.11 -> Q0.22, never -0.
module sm_frac_mult
    import nn_pkg::*;
(
    input  in_sm_t  x,
    input  in_sm_t  w,
    output acc_sm_t prod
);

    logic [21:0] mag_s;

    // Multiply magnitudes; the sign survives only on a nonzero product.
    always_comb begin
        mag_s = 22'({11'h000, x.mag} * {11'h000, w.mag});
        prod.mag = mag_s;
        if (mag_s == 22'h000000) begin
            prod.sign = 1'b0;
        end else begin
            prod.sign = x.sign ^ w.sign;
        end
    end

endmodule

// File: rtl/fraction_mac_relu.sv
// Single-neuron MAC: bias + sum(x*w) in sign-magnitude, ReLU on the last term.
module fraction_mac_relu
    import nn_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ACC_W-1:0]   bias,
    input  logic               in_valid,
    input  logic [IN_W-1:0]    in_x,
    input  logic [IN_W-1:0]    in_w,
    input  logic               in_last,
    output logic [ACC_W-1:0]   out_data,
    output logic               out_valid
);

    acc_sm_t acc_r;
    acc_sm_t out_data_r;
    logic    out_valid_r;

    acc_sm_t bias_s;
    acc_sm_t prod_s;
    acc_sm_t add_a_s;
    acc_sm_t sum_s;
    acc_sm_t acc_next_s;
    acc_sm_t relu_s;

    assign bias_s = acc_sm_t'(bias);

    sm_frac_mult u_mult (
        .x    (in_sm_t'(in_x)),
        .w    (in_sm_t'(in_w)),
        .prod (prod_s)
    );

    sm_add_sat u_add (
        .a   (add_a_s),
        .b   (prod_s),
        .sum (sum_s)
    );

    // A start restarts from the bias, otherwise keep adding onto the running sum.
    always_comb begin
        if (start) begin
            add_a_s = bias_s;
        end else begin
            add_a_s = acc_r;
        end
    end

    // Next accumulator value, start taking precedence over plain accumulation.
    always_comb begin
        acc_next_s = acc_r;
        if (start && in_valid) begin
            acc_next_s = sum_s;
        end else if (start) begin
            acc_next_s = bias_s;
        end else if (in_valid) begin
            acc_next_s = sum_s;
        end else begin
            acc_next_s = acc_r;
        end
        relu_s = relu(acc_next_s);
    end

    // Accumulator and registered ReLU output with its one-cycle valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r       <= acc_sm_t'(23'h000000);
            out_data_r  <= acc_sm_t'(23'h000000);
            out_valid_r <= 1'b0;
        end else begin
            acc_r <= acc_next_s;
            if (in_valid && in_last) begin
                out_data_r  <= relu_s;
                out_valid_r <= 1'b1;
            end else begin
                out_data_r  <= out_data_r;
                out_valid_r <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_fraction_mac_relu.sv
// Directed and random checks of fraction_mac_relu against an integer model.
module tb_fraction_mac_relu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [22:0] bias;
    logic        in_valid;
    logic [11:0] in_x;
    logic [11:0] in_w;
    logic        in_last;
    logic [22:0] out_data;
    logic        out_valid;

    int n_assert;
    int n_fail;

    // Reference state as plain signed integers (value in units of 2^-22).
    int m_acc;
    int m_out;
    bit m_valid;

    fraction_mac_relu dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_x      (in_x),
        .in_w      (in_w),
        .in_last   (in_last),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sm12_val(input logic [11:0] v);
        int m;
        m = int'(v[10:0]);
        return v[11] ? -m : m;
    endfunction

    function automatic int sm23_val(input logic [22:0] v);
        int m;
        m = int'(v[21:0]);
        return v[22] ? -m : m;
    endfunction

    function automatic logic [22:0] val_sm23(input int v);
        logic [21:0] m;
        if (v < 0) begin
            m = 22'(-v);
            return {1'b1, m};
        end
        m = 22'(v);
        return {1'b0, m};
    endfunction

    function automatic int clamp(input int v);
        if (v > 32'sh3FFFFF)  return 32'sh3FFFFF;
        if (v < -32'sh3FFFFF) return -32'sh3FFFFF;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [22:0] obs, input logic [22:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare outputs.
    task automatic step(input logic r, input logic s, input logic v, input logic l,
                        input logic [22:0] b, input logic [11:0] x, input logic [11:0] w);
        int p;
        logic [22:0] acc_obs;
        rst = r; start = s; in_valid = v; in_last = l; bias = b; in_x = x; in_w = w;
        @(posedge clk);
        p = sm12_val(x) * sm12_val(w);
        if (r) begin
            m_acc = 0; m_out = 0; m_valid = 1'b0;
        end else begin
            if (s && v)      m_acc = clamp(sm23_val(b) + p);
            else if (s)      m_acc = sm23_val(b);
            else if (v)      m_acc = clamp(m_acc + p);
            if (v && l) begin
                m_out   = (m_acc > 0) ? m_acc : 0;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        acc_obs = dut.acc_r;
        chk("out_valid", {22'h0, out_valid}, {22'h0, m_valid});
        chk("out_data", out_data, val_sm23(m_out));
        chk("acc", acc_obs, val_sm23(m_acc));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 23'h0, 12'h0, 12'h0);
    endtask

    initial begin
        logic [22:0] rb;
        logic [11:0] rx;
        logic [11:0] rw;
        n_assert = 0; n_fail = 0;
        m_acc = 0; m_out = 0; m_valid = 1'b0;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        bias = 23'h0; in_x = 12'h0; in_w = 12'h0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 23'h0, 12'h0, 12'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 23'h0, 12'h0, 12'h0);
        chk("reset_out", out_data, 23'h000000);
        chk("reset_valid", {22'h0, out_valid}, 23'h0);

        // Positive product, single-term sequence
        step(1'b0, 1'b1, 1'b1, 1'b1, 23'h000000, 12'h400, 12'h400);
        chk("pos_valid", {22'h0, out_valid}, 23'h1);
        chk("pos_data", out_data, 23'h100000);
        idle();
        chk("pos_pulse_end", {22'h0, out_valid}, 23'h0);
        chk("pos_hold", out_data, 23'h100000);

        // Negative sum clipped by ReLU
        step(1'b0, 1'b1, 1'b1, 1'b1, 23'h000000, 12'hC00, 12'h400);
        chk("neg_acc", dut.acc_r, 23'h500000);
        chk("neg_data", out_data, 23'h000000);

        // Cancellation gives +0
        step(1'b0, 1'b1, 1'b1, 1'b1, 23'h100000, 12'hC00, 12'h400);
        chk("cancel_acc", dut.acc_r, 23'h000000);
        chk("cancel_data", out_data, 23'h000000);

        // Saturation
        step(1'b0, 1'b1, 1'b1, 1'b1, 23'h3FFFFF, 12'h400, 12'h400);
        chk("sat_data", out_data, 23'h3FFFFF);
        idle();

        // Three-term sequence: pulse only after the third term
        step(1'b0, 1'b1, 1'b1, 1'b0, 23'h040000, 12'h400, 12'h400);
        chk("seq3_t1_valid", {22'h0, out_valid}, 23'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 23'h0, 12'h200, 12'hA00);
        chk("seq3_t2_valid", {22'h0, out_valid}, 23'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 23'h0, 12'h7FF, 12'h000);
        chk("seq3_valid", {22'h0, out_valid}, 23'h1);
        chk("seq3_data", out_data, 23'h100000);
        idle();
        chk("seq3_pulse_end", {22'h0, out_valid}, 23'h0);

        // in_last without in_valid is ignored
        step(1'b0, 1'b0, 1'b0, 1'b1, 23'h0, 12'h400, 12'h400);
        chk("last_only", {22'h0, out_valid}, 23'h0);

        // Reset after the second term aborts the sequence
        step(1'b0, 1'b1, 1'b1, 1'b0, 23'h020000, 12'h400, 12'h200);
        step(1'b0, 1'b0, 1'b1, 1'b0, 23'h0, 12'h300, 12'h100);
        step(1'b1, 1'b0, 1'b1, 1'b1, 23'h0, 12'h400, 12'h400);
        chk("rst_acc", dut.acc_r, 23'h000000);
        chk("rst_data", out_data, 23'h000000);
        chk("rst_valid", {22'h0, out_valid}, 23'h0);
        // New sequence after reset, back-to-back with a second one
        step(1'b0, 1'b1, 1'b1, 1'b0, 23'h010000, 12'h400, 12'h400);
        step(1'b0, 1'b0, 1'b1, 1'b1, 23'h0, 12'h200, 12'h200);
        chk("post_rst_data", out_data, 23'h150000);
        step(1'b0, 1'b1, 1'b1, 1'b1, 23'h000000, 12'h200, 12'h200);
        chk("b2b_valid", {22'h0, out_valid}, 23'h1);
        chk("b2b_data", out_data, 23'h040000);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rb = 23'($urandom);
            if (rb[21:0] == 22'h0) rb[22] = 1'b0;
            rx = 12'($urandom);
            rw = 12'($urandom);
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 4) == 0),
                 rb, rx, rw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fraction_mac_relu.md
# fraction_mac_relu

Single-neuron datapath for the hidden layer. It multiplies 12-bit sign-magnitude fractional inputs by 12-bit weights and accumulates the products onto a 23-bit bias in a sign-magnitude adder. At the end of each term sequence it applies ReLU and presents one registered result. The control FSM feeding inputs and weights (the neuron wrapper) sits above this block.

## Interface
- No parameters; the term count is set by `in_last`.
- `clk`  in  1  clock. Reset `rst`, synchronous, active-high; clock `clk`.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  begins a new sequence; loads `bias` into the accumulator.
- `bias`  in  23  bias, sign-magnitude Q0.22, sampled only when `start`=1.
- `in_valid`  in  1  a term (`in_x`, `in_w`) is presented this cycle.
- `in_x`  in  12  input, sign-magnitude: bit 11 sign, bits 10:0 magnitude Q0.11.
- `in_w`  in  12  weight, same format as `in_x`.
- `in_last`  in  1  the current term is the final one; qualified by `in_valid`.
- `out_data`  out  23  ReLU(accumulated sum), sign-magnitude Q0.22.
- `out_valid`  out  1  one-cycle pulse when `out_data` is updated.

## Operation
- **Multiplier (combinational).**
  - `prod[22]` = `x[11]` XOR `w[11]`.
  - `prod[21:0]` = `x[10:0]` × `w[10:0]`.
  - A zero magnitude forces the sign to 0. Maximum magnitude is 22'h3FF001.
- **Sign-magnitude adder (combinational), `a + b`:**
  - Same signs: add the magnitudes; the result keeps that sign.
  - If the magnitude sum exceeds 22'h3FFFFF, saturate it to 22'h3FFFFF.
  - Different signs: subtract the smaller magnitude from the larger; the result takes the sign of the larger.
  - Equal magnitudes give +0.
  - A result of −0 never appears.
- **ReLU (combinational):** output 0 if bit 22 = 1, otherwise pass the value through.
- **Accumulator `acc` (23-bit register). Next-value rules, in priority order:**
  1. `rst`: `acc` ← 0.
  2. `start` & `in_valid`: `acc` ← bias + prod.
  3. `start` alone: `acc` ← bias.
  4. `in_valid` alone: `acc` ← acc + prod.
  5. Otherwise `acc` holds.
- **Output:**
  - On a clock edge where `in_valid` & `in_last` = 1: `out_data` ← ReLU(acc_next) and `out_valid` ← 1.
  - On every other edge `out_valid` ← 0.
  - `out_data` holds its value until the next last-term edge or reset.
- **Sequencing:**
  - `in_valid` without a prior `start` accumulates onto the current `acc`. This is legal, with no error flag.
  - `start` arriving mid-sequence discards the partial sum.

## Timing
- Reset values: `acc` = 0, `out_data` = 0, `out_valid` = 0.
- `rst` mid-sequence aborts the sequence; no `out_valid` is produced for it.
- Throughput is one term per cycle, with no back-pressure.
- Latency:
  - `out_valid` is high in the cycle after the edge that accepts the last term.
  - For N terms with `start` on the first term, the first term is accepted at edge 1 and `out_valid` is high after edge N.
- `start` & `in_valid` & `in_last` in the same cycle is a single-term sequence. Its output is valid the next cycle.
- `in_last` without `in_valid` is ignored.
- Back-to-back sequences are allowed: `start` may coincide with the cycle in which `out_valid` is high.

## Structure
- Shared package `nn_pkg`:
  - `IN_W` = 12, `ACC_W` = 23, `MAG_MAX` = 22'h3FFFFF.
  - Typedefs `in_sm_t` (sign, mag[10:0]) and `acc_sm_t` (sign, mag[21:0]).
- Sub-modules: `sm_frac_mult` (multiplier) and `sm_add_sat` (adder). ReLU is inlined.
- The top holds only `acc`, `out_data` and `out_valid`.

## Test plan
- **Positive product.** `start`, `in_valid`, `in_last`; bias = 0, `in_x` = 12'h400, `in_w` = 12'h400 → next cycle `out_valid` = 1, `out_data` = 23'h100000.
- **Negative sum clipped by ReLU.** Same as above with `in_x` = 12'hC00 → internal `acc` = 23'h500000, `out_data` = 0.
- **Cancellation.** bias = 23'h100000 plus term 12'hC00 × 12'h400 → sum is +0, `out_data` = 23'h000000 (sign bit 0).
- **Saturation.** bias = 23'h3FFFFF plus term 12'h400 × 12'h400 → `out_data` = 23'h3FFFFF.
- **Three-term sequence.**
  - bias = 23'h040000.
  - Terms: (12'h400, 12'h400), (12'h200, 12'hA00) = −0.0625, (12'h7FF, 12'h000).
  - Required: `out_valid` exactly one cycle, 3 cycles after `start`; `out_data` = 23'h100000.
- **Reset mid-sequence.** Assert `rst` after the 2nd term → `acc` and `out_data` = 0 and no `out_valid` pulse. A new sequence then runs correctly.
